stream_decryptor: RTL

STREAM_DECRYPTOR -- requirements
Module: stream_decryptor

---
 rtl/stream_decryptor.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/stream_decryptor.sv
// Byte-oriented stream decryptor built on three majority-clocked LFSRs.
// The session key and the public frame value are shifted into the LFSRs,
// then the LFSRs are warmed up. After that, each ciphertext byte is XORed
// MSB first with one keystream bit per cycle.
module stream_decryptor #(
  parameter int MIX_CYCLES = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] secret_key,
  input  logic [21:0] public_key,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [7:0]  m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        keyed
);

  localparam int LOAD_CYCLES = 86;
  localparam int CNT_MAX     = (MIX_CYCLES > LOAD_CYCLES) ? MIX_CYCLES : LOAD_CYCLES;
  localparam int CW          = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MIX, S_WAIT, S_DEC, S_OUT} state_t;

  state_t        state_q, state_d;
  logic [18:0]   r1_q, r1_d;
  logic [21:0]   r2_q, r2_d;
  logic [22:0]   r3_q, r3_d;
  logic [85:0]   key_q, key_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    cipher_q, cipher_d;
  logic [7:0]    plain_q, plain_d;
  logic [7:0]    m_data_q, m_data_d;
  logic          keyed_q, keyed_d;

  // Feedback, keystream and majority-clock terms, all from the current register contents.
  logic        fb1, fb2, fb3, ks, maj, plain_bit, start_ok;
  logic [18:0] r1_maj;
  logic [21:0] r2_maj;
  logic [22:0] r3_maj;

  assign fb1 = r1_q[13] ^ r1_q[16] ^ r1_q[17] ^ r1_q[18];
  assign fb2 = r2_q[20] ^ r2_q[21];
  assign fb3 = r3_q[7] ^ r3_q[20] ^ r3_q[21] ^ r3_q[22];
  assign ks  = r1_q[18] ^ r2_q[21] ^ r3_q[22];
  assign maj = (r1_q[8] & r2_q[10]) | (r1_q[8] & r3_q[10]) | (r2_q[10] & r3_q[10]);

  assign r1_maj = (r1_q[8]  == maj) ? {r1_q[17:0], fb1} : r1_q;
  assign r2_maj = (r2_q[10] == maj) ? {r2_q[20:0], fb2} : r2_q;
  assign r3_maj = (r3_q[10] == maj) ? {r3_q[21:0], fb3} : r3_q;

  assign plain_bit = cipher_q[7] ^ ks;
  assign start_ok  = start && ((state_q == S_IDLE) || (state_q == S_WAIT));

  // A start in the same cycle as a byte wins, so the byte is refused rather than dropped.
  assign s_ready = (state_q == S_WAIT) && !start;
  assign m_valid = (state_q == S_OUT);
  assign m_data  = m_data_q;
  assign keyed   = keyed_q;

  // Next-state logic: sequencing, LFSR stepping and byte assembly.
  always_comb begin
    state_d  = state_q;
    r1_d     = r1_q;
    r2_d     = r2_q;
    r3_d     = r3_q;
    key_d    = key_q;
    cnt_d    = cnt_q;
    cipher_d = cipher_q;
    plain_d  = plain_q;
    m_data_d = m_data_q;
    keyed_d  = keyed_q;
    case (state_q)
      S_IDLE, S_WAIT: begin
        if (start_ok) begin
          state_d = S_LOAD;
          key_d   = {secret_key, public_key};
          r1_d    = '0;
          r2_d    = '0;
          r3_d    = '0;
          cnt_d   = '0;
          keyed_d = 1'b0;
        end else if ((state_q == S_WAIT) && s_valid) begin
          state_d  = S_DEC;
          cipher_d = s_data;
          cnt_d    = '0;
        end
      end
      S_LOAD: begin
        r1_d  = {r1_q[17:0], fb1 ^ key_q[85]};
        r2_d  = {r2_q[20:0], fb2 ^ key_q[85]};
        r3_d  = {r3_q[21:0], fb3 ^ key_q[85]};
        key_d = {key_q[84:0], 1'b0};
        if (cnt_q == CW'(LOAD_CYCLES - 1)) begin
          state_d = S_MIX;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_MIX: begin
        r1_d = r1_maj;
        r2_d = r2_maj;
        r3_d = r3_maj;
        if (cnt_q == CW'(MIX_CYCLES - 1)) begin
          state_d = S_WAIT;
          keyed_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DEC: begin
        r1_d     = r1_maj;
        r2_d     = r2_maj;
        r3_d     = r3_maj;
        plain_d  = {plain_q[6:0], plain_bit};
        cipher_d = {cipher_q[6:0], 1'b0};
        if (cnt_q == CW'(7)) begin
          state_d  = S_OUT;
          m_data_d = {plain_q[6:0], plain_bit};
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_OUT: begin
        if (m_ready) state_d = S_WAIT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset abandons any key setup or partial byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      r1_q     <= '0;
      r2_q     <= '0;
      r3_q     <= '0;
      key_q    <= '0;
      cnt_q    <= '0;
      cipher_q <= '0;
      plain_q  <= '0;
      m_data_q <= '0;
      keyed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      r1_q     <= r1_d;
      r2_q     <= r2_d;
      r3_q     <= r3_d;
      key_q    <= key_d;
      cnt_q    <= cnt_d;
      cipher_q <= cipher_d;
      plain_q  <= plain_d;
      m_data_q <= m_data_d;
      keyed_q  <= keyed_d;
    end
  end

endmodule
